// File: rtl/gfx_cmd_parser.sv
// Byte-stream command parser: collects an opcode plus little-endian operand fields
// and issues one registered raster packet. Bad opcodes and stalled operands raise err_valid.
module gfx_cmd_parser #(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_op,
  output logic [COORD_W-1:0] out_xs,
  output logic [COORD_W-1:0] out_ys,
  output logic [COORD_W-1:0] out_xe,
  output logic [COORD_W-1:0] out_ye,
  output logic [COLOR_W-1:0] out_color,
  output logic               err_valid,
  output logic [1:0]         err_code,
  output logic               busy
);

  localparam int BPC  = (COORD_W + DATA_W - 1) / DATA_W;
  localparam int BPK  = (COLOR_W + DATA_W - 1) / DATA_W;
  localparam int MAXB = (BPC > BPK) ? BPC : BPK;
  localparam int SHW  = MAXB * DATA_W;
  localparam int BIW  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OP_LINE  = 2'd0;
  localparam logic [1:0] OP_RECT  = 2'd1;
  localparam logic [1:0] OP_PIXEL = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] F_XS  = 3'd0;
  localparam logic [2:0] F_YS  = 3'd1;
  localparam logic [2:0] F_XE  = 3'd2;
  localparam logic [2:0] F_YE  = 3'd3;
  localparam logic [2:0] F_COL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_OPERAND, S_ISSUE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [2:0]         fid_q;
  logic [BIW-1:0]     bidx_q;
  logic [TW-1:0]      tcnt_q;
  logic [SHW-1:0]     sh_q;
  logic [COORD_W-1:0] xs_q, ys_q, xe_q, ye_q;

  logic               op_ok;
  logic [1:0]         op_dec;
  logic               xfer;
  logic               field_last;
  logic               tmo_hit;
  logic [SHW-1:0]     asm_full;
  logic [COORD_W-1:0] coord_asm;
  logic [COLOR_W-1:0] color_asm;

  // Handshake: a byte moves on any rising edge where in_valid & in_ready; a packet
  // leaves on any rising edge where out_valid & out_ready, and is held stable until then.

  always_comb begin
    op_ok  = 1'b1;
    op_dec = OP_LINE;
    if (in_data == DATA_W'(8'h4C))      op_dec = OP_LINE;
    else if (in_data == DATA_W'(8'h52)) op_dec = OP_RECT;
    else if (in_data == DATA_W'(8'h50)) op_dec = OP_PIXEL;
    else if (in_data == DATA_W'(8'h43)) op_dec = OP_CLEAR;
    else                                op_ok  = 1'b0;
  end

  assign xfer       = in_valid & in_ready;
  assign field_last = (fid_q == F_COL) ? (bidx_q == BIW'(BPK - 1))
                                       : (bidx_q == BIW'(BPC - 1));
  assign tmo_hit    = (tcnt_q == TW'(TIMEOUT - 1));

  // Bytes shift in from the top, so after n bytes the field sits in the top n bytes.
  assign asm_full  = SHW'({in_data, sh_q} >> DATA_W);
  assign coord_asm = COORD_W'(asm_full >> ((MAXB - BPC) * DATA_W));
  assign color_asm = COLOR_W'(asm_full >> ((MAXB - BPK) * DATA_W));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && op_ok) state_d = S_OPERAND;
      end
      S_OPERAND: begin
        in_ready = 1'b1;
        if (in_valid && fid_q == F_COL && field_last) state_d = S_ISSUE;
        else if (!in_valid && tmo_hit)                state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign out_valid = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      fid_q     <= '0;
      bidx_q    <= '0;
      tcnt_q    <= '0;
      sh_q      <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      out_op    <= '0;
      out_xs    <= '0;
      out_ys    <= '0;
      out_xe    <= '0;
      out_ye    <= '0;
      out_color <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            if (op_ok) begin
              op_q   <= op_dec;
              fid_q  <= (op_dec == OP_CLEAR) ? F_COL : F_XS;
              bidx_q <= '0;
              tcnt_q <= '0;
              sh_q   <= '0;
            end else if (in_data != '0) begin
              err_valid <= 1'b1;
              err_code  <= 2'd1;
            end
          end
        end
        S_OPERAND: begin
          if (xfer) begin
            tcnt_q <= '0;
            if (field_last) begin
              bidx_q <= '0;
              sh_q   <= '0;
              fid_q  <= (fid_q == F_YS && op_q == OP_PIXEL) ? F_COL : fid_q + 3'd1;
              case (fid_q)
                F_XS: xs_q <= coord_asm;
                F_YS: ys_q <= coord_asm;
                F_XE: xe_q <= coord_asm;
                F_YE: ye_q <= coord_asm;
                default: begin
                  out_op    <= op_q;
                  out_color <= color_asm;
                  case (op_q)
                    OP_RECT: begin
                      out_xs <= (xs_q <= xe_q) ? xs_q : xe_q;
                      out_xe <= (xs_q <= xe_q) ? xe_q : xs_q;
                      out_ys <= (ys_q <= ye_q) ? ys_q : ye_q;
                      out_ye <= (ys_q <= ye_q) ? ye_q : ys_q;
                    end
                    OP_PIXEL: begin
                      out_xs <= xs_q;
                      out_xe <= xs_q;
                      out_ys <= ys_q;
                      out_ye <= ys_q;
                    end
                    OP_CLEAR: begin
                      out_xs <= '0;
                      out_ys <= '0;
                      out_xe <= '1;
                      out_ye <= '1;
                    end
                    default: begin
                      out_xs <= xs_q;
                      out_ys <= ys_q;
                      out_xe <= xe_q;
                      out_ye <= ye_q;
                    end
                  endcase
                end
              endcase
            end else begin
              sh_q   <= asm_full;
              bidx_q <= bidx_q + BIW'(1);
            end
          end else if (tmo_hit) begin
            err_valid <= 1'b1;
            err_code  <= 2'd2;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
